// File: rtl/gate_sweep_ctrl.sv
// Truth-table sweep controller for a two-input gate under test: walks vectors
// 00..11, holds each for HOLD_CYCLES, samples F and accumulates mismatches.
module gate_sweep_ctrl #(
    parameter int HOLD_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       abort,
    input  logic [2:0] op_sel,
    output logic       gate_a,
    output logic       gate_b,
    input  logic       gate_f,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [2:0] err_cnt,
    output logic [3:0] fail_mask
);

    // A hold of zero is treated as one; anything above 255 saturates.
    localparam int         HOLD_EFF  = (HOLD_CYCLES < 1) ? 1 :
                                       ((HOLD_CYCLES > 255) ? 255 : HOLD_CYCLES);
    localparam logic [7:0] HOLD_LAST = 8'(HOLD_EFF - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        APPLY  = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t     state_reg;
    logic [1:0] vec_reg;
    logic [7:0] hold_reg;
    logic [2:0] op_reg;

    logic       expected_f;
    logic       mismatch;
    logic [1:0] vec_next;

    always_comb begin
        expected_f = 1'b0;
        case (op_reg)
            3'd0:    expected_f =   vec_reg[1] & vec_reg[0];
            3'd1:    expected_f =   vec_reg[1] | vec_reg[0];
            3'd2:    expected_f = ~(vec_reg[1] & vec_reg[0]);
            3'd3:    expected_f = ~(vec_reg[1] | vec_reg[0]);
            3'd4:    expected_f =   vec_reg[1] ^ vec_reg[0];
            3'd5:    expected_f = ~(vec_reg[1] ^ vec_reg[0]);
            default: expected_f = ~(vec_reg[1] | vec_reg[0]);
        endcase
        mismatch = (gate_f != expected_f);
        vec_next = vec_reg + 2'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            vec_reg   <= 2'd0;
            hold_reg  <= 8'd0;
            op_reg    <= 3'd0;
            gate_a    <= 1'b0;
            gate_b    <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            err_cnt   <= 3'd0;
            fail_mask <= 4'd0;
        end else begin
            case (state_reg)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        op_reg    <= op_sel;
                        vec_reg   <= 2'd0;
                        hold_reg  <= 8'd0;
                        err_cnt   <= 3'd0;
                        fail_mask <= 4'd0;
                        pass      <= 1'b0;
                        gate_a    <= 1'b0;
                        gate_b    <= 1'b0;
                        busy      <= 1'b1;
                        state_reg <= APPLY;
                    end
                end
                APPLY: begin
                    if (abort) begin
                        gate_a    <= 1'b0;
                        gate_b    <= 1'b0;
                        busy      <= 1'b0;
                        pass      <= 1'b0;
                        state_reg <= IDLE;
                    end else if (hold_reg == HOLD_LAST) begin
                        state_reg <= SAMPLE;
                    end else begin
                        hold_reg <= hold_reg + 8'd1;
                    end
                end
                SAMPLE: begin
                    if (abort) begin
                        // A mismatch seen in the aborted cycle is deliberately dropped.
                        gate_a    <= 1'b0;
                        gate_b    <= 1'b0;
                        busy      <= 1'b0;
                        pass      <= 1'b0;
                        state_reg <= IDLE;
                    end else begin
                        if (mismatch) begin
                            err_cnt            <= err_cnt + 3'd1;
                            fail_mask[vec_reg] <= 1'b1;
                        end
                        if (vec_reg == 2'd3) begin
                            gate_a    <= 1'b0;
                            gate_b    <= 1'b0;
                            busy      <= 1'b0;
                            done      <= 1'b1;
                            pass      <= (err_cnt == 3'd0) && !mismatch;
                            state_reg <= DONE;
                        end else begin
                            vec_reg   <= vec_next;
                            hold_reg  <= 8'd0;
                            gate_a    <= vec_next[1];
                            gate_b    <= vec_next[0];
                            state_reg <= APPLY;
                        end
                    end
                end
                DONE: begin
                    done      <= 1'b0;
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gate_sweep_ctrl.sv
// Randomised bench for gate_sweep_ctrl: three instances (hold 4, 1, 0) each drive
// a truth-table gate model; results are checked against a per-cycle reference.
module tb_gate_sweep_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start_drv = 1'b0;
    logic       abort_drv = 1'b0;
    logic [2:0] op_drv = 3'd0;
    logic [3:0] f_tab = 4'b0001;
    int         sel = 0;

    logic       st [3];
    logic       ab [3];
    logic       ga [3];
    logic       gb [3];
    logic       gf [3];
    logic       bz [3];
    logic       dn [3];
    logic       ps [3];
    logic [2:0] ec [3];
    logic [3:0] fm [3];

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_dut
            assign st[gi] = start_drv && (sel == gi);
            assign ab[gi] = abort_drv && (sel == gi);
            assign gf[gi] = f_tab[{ga[gi], gb[gi]}];
            gate_sweep_ctrl #(.HOLD_CYCLES((gi == 0) ? 4 : ((gi == 1) ? 1 : 0))) u_dut (
                .clk       (clk),
                .rst_n     (rst_n),
                .start     (st[gi]),
                .abort     (ab[gi]),
                .op_sel    (op_drv),
                .gate_a    (ga[gi]),
                .gate_b    (gb[gi]),
                .gate_f    (gf[gi]),
                .busy      (bz[gi]),
                .done      (dn[gi]),
                .pass      (ps[gi]),
                .err_cnt   (ec[gi]),
                .fail_mask (fm[gi])
            );
        end
    endgenerate

    function automatic logic ref_fn(input logic [2:0] op, input logic a, input logic b);
        case (op)
            3'd0:    return a & b;
            3'd1:    return a | b;
            3'd2:    return !(a & b);
            3'd3:    return !(a | b);
            3'd4:    return a ^ b;
            3'd5:    return !(a ^ b);
            default: return !(a | b);
        endcase
    endfunction

    // Vector v is sampled in the cycle at offset v*(h+1)+h after the start edge;
    // its verdict is visible from the following cycle on.
    function automatic logic [3:0] exp_mask(input logic [3:0] tab, input logic [2:0] op,
                                            input int k, input int h);
        logic [3:0] m;
        m = 4'd0;
        for (int v = 0; v < 4; v++) begin
            logic [1:0] vv;
            vv = 2'(v);
            if ((v * (h + 1) + h < k) && (tab[v] != ref_fn(op, vv[1], vv[0])))
                m[v] = 1'b1;
        end
        return m;
    endfunction

    function automatic int hold_of(input int d);
        return (d == 0) ? 4 : 1;
    endfunction

    // One sweep on DUT d. abort_k >= 0 aborts while the state at offset abort_k is live.
    task automatic run_sweep(input int d, input logic [3:0] tab, input logic [2:0] op,
                             input int abort_k, input bit noise, input bit abort_with_start);
        int h, n;
        logic [3:0] m;
        logic [8:0] obs, exp;
        logic prev_pass;
        bit saw_done;
        h = hold_of(d);
        n = 4 * (h + 1);
        sel = d;
        f_tab = tab;
        @(negedge clk);
        start_drv = 1'b1;
        op_drv = op;
        if (abort_with_start) abort_drv = 1'b1;
        for (int k = 0; k <= n; k++) begin
            @(negedge clk);
            start_drv = 1'b0;
            abort_drv = 1'b0;
            if (k == n) begin
                m = exp_mask(tab, op, n, h);
                obs = {bz[d], dn[d], ga[d], gb[d], ps[d], fm[d]};
                exp = {1'b0, 1'b1, 1'b0, 1'b0, (m == 4'd0), m};
                tests_run++;
                if (obs !== exp) begin
                    tests_failed++;
                    $display("FAIL done_cycle dut=%0d got busy/done/a/b/pass/mask=%b want %b", d, obs, exp);
                end
                tests_run++;
                if (ec[d] !== 3'($countones(m))) begin
                    tests_failed++;
                    $display("FAIL err_cnt dut=%0d got %0d want %0d", d, ec[d], $countones(m));
                end
                prev_pass = (m == 4'd0);
                if (noise) start_drv = 1'b1;
                @(negedge clk);
                start_drv = 1'b0;
                for (int j = 0; j < 2; j++) begin
                    tests_run++;
                    if ({bz[d], dn[d], ps[d]} !== {1'b0, 1'b0, prev_pass}) begin
                        tests_failed++;
                        $display("FAIL post_done dut=%0d got busy/done/pass=%b want 00%b",
                                 d, {bz[d], dn[d], ps[d]}, prev_pass);
                    end
                    @(negedge clk);
                end
                $display("[TB] sweep dut=%0d hold=%0d op=%0d tab=%b err=%0d mask=%b pass=%b",
                         d, h, op, tab, ec[d], fm[d], ps[d]);
                return;
            end
            m = exp_mask(tab, op, k, h);
            obs = {bz[d], dn[d], ga[d], gb[d], ps[d], fm[d]};
            exp = {1'b1, 1'b0, 2'(k / (h + 1)), 1'b0, m};
            tests_run++;
            if (obs !== exp) begin
                tests_failed++;
                $display("FAIL sweep_cycle dut=%0d k=%0d got %b want %b", d, k, obs, exp);
            end
            if (k == abort_k) begin
                abort_drv = 1'b1;
                @(negedge clk);
                abort_drv = 1'b0;
                obs = {bz[d], dn[d], ga[d], gb[d], ps[d], fm[d]};
                exp = {4'b0000, 1'b0, m};
                tests_run++;
                if (obs !== exp || ec[d] !== 3'($countones(m))) begin
                    tests_failed++;
                    $display("FAIL abort dut=%0d k=%0d got %b err=%0d want %b err=%0d",
                             d, k, obs, ec[d], exp, $countones(m));
                end
                saw_done = 1'b0;
                for (int j = 0; j < n + 2; j++) begin
                    @(negedge clk);
                    if (dn[d] || bz[d]) saw_done = 1'b1;
                end
                tests_run++;
                if (saw_done) begin
                    tests_failed++;
                    $display("FAIL abort_quiet dut=%0d got activity=1 want 0", d);
                end
                $display("[TB] sweep dut=%0d hold=%0d op=%0d tab=%b aborted_at=%0d err=%0d mask=%b",
                         d, h, op, tab, k, ec[d], fm[d]);
                return;
            end
            if (noise) begin
                op_drv = 3'($urandom);
                if (k == 3) start_drv = 1'b1;
            end
        end
    endtask

    task automatic test_reset();
        sel = 0;
        #1;
        for (int d = 0; d < 3; d++) begin
            tests_run++;
            if ({ga[d], gb[d], bz[d], dn[d], ps[d], ec[d], fm[d]} !== 12'd0) begin
                tests_failed++;
                $display("FAIL reset dut=%0d got %b want 0", d,
                         {ga[d], gb[d], bz[d], dn[d], ps[d], ec[d], fm[d]});
            end
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        $display("[TB] reset released");
    endtask

    task automatic test_nor_ideal();      run_sweep(0, 4'b0001, 3'd3, -1, 1'b0, 1'b0); endtask
    task automatic test_tied_zero();      run_sweep(0, 4'b0000, 3'd3, -1, 1'b0, 1'b0); endtask
    task automatic test_xor_on_nor();     run_sweep(0, 4'b0001, 3'd4, -1, 1'b0, 1'b0); endtask
    task automatic test_abort_vec2();     run_sweep(0, 4'b0001, 3'd3, 11, 1'b0, 1'b0); endtask
    task automatic test_start_ignored();  run_sweep(0, 4'b0001, 3'd3, -1, 1'b1, 1'b0); endtask
    task automatic test_start_beats_abort(); run_sweep(0, 4'b0001, 3'd3, -1, 1'b0, 1'b1); endtask

    task automatic test_abort_idle();
        run_sweep(0, 4'b0001, 3'd3, -1, 1'b0, 1'b0);
        @(negedge clk);
        abort_drv = 1'b1;
        @(negedge clk);
        abort_drv = 1'b0;
        tests_run++;
        if ({bz[0], dn[0], ps[0], ec[0], fm[0]} !== {3'b001, 7'd0}) begin
            tests_failed++;
            $display("FAIL abort_idle got %b want 0010000000", {bz[0], dn[0], ps[0], ec[0], fm[0]});
        end
        $display("[TB] abort in idle pass=%b", ps[0]);
    endtask

    task automatic test_reset_mid();
        sel = 0;
        f_tab = 4'b0000;
        @(negedge clk);
        start_drv = 1'b1;
        op_drv = 3'd3;
        @(negedge clk);
        start_drv = 1'b0;
        repeat (7) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        tests_run++;
        if ({ga[0], gb[0], bz[0], dn[0], ps[0], ec[0], fm[0]} !== 12'd0) begin
            tests_failed++;
            $display("FAIL reset_mid got %b want 0", {ga[0], gb[0], bz[0], dn[0], ps[0], ec[0], fm[0]});
        end
        @(negedge clk);
        rst_n = 1'b1;
        $display("[TB] reset mid-sweep");
        run_sweep(0, 4'b0001, 3'd3, -1, 1'b0, 1'b0);
    endtask

    task automatic test_short_hold();
        run_sweep(1, 4'b0001, 3'd3, -1, 1'b0, 1'b0);
        run_sweep(2, 4'b0001, 3'd3, -1, 1'b0, 1'b0);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 24; i++) begin
            int d, ak;
            d = int'($urandom_range(0, 2));
            ak = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 4 * (hold_of(d) + 1) - 1)) : -1;
            run_sweep(d, 4'($urandom), 3'($urandom), ak, 1'($urandom), 1'($urandom));
        end
    endtask

    initial begin
        test_reset();
        test_nor_ideal();
        test_tied_zero();
        test_xor_on_nor();
        test_abort_vec2();
        test_start_ignored();
        test_start_beats_abort();
        test_abort_idle();
        test_reset_mid();
        test_short_hold();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/gate_sweep_ctrl.md
GATE_SWEEP_CTRL -- requirements
Module: gate_sweep_ctrl

Interface
REQ-001 Parameter: HOLD_CYCLES, default 4, number of cycles each input vector is applied before the gate output is sampled; legal range 1..255; value 0 SHALL behave as 1.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 start  input  1  begin one truth-table sweep; sampled only in IDLE.
REQ-005 abort  input  1  terminate sweep in progress; synchronous.
REQ-006 op_sel  input  3  expected gate function: 0 AND, 1 OR, 2 NAND, 3 NOR, 4 XOR, 5 XNOR, 6/7 treated as NOR.
REQ-007 gate_a  output  1  drives gate-under-test input A.
REQ-008 gate_b  output  1  drives gate-under-test input B.
REQ-009 gate_f  input  1  gate-under-test output F.
REQ-010 busy  output  1  high while a sweep is in progress.
REQ-011 done  output  1  one-cycle pulse at sweep completion.
REQ-012 pass  output  1  1 when last completed sweep had zero mismatches.
REQ-013 err_cnt  output  3  mismatch count of current/last sweep, 0..4.
REQ-014 fail_mask  output  4  bit i set when vector i mismatched; vector i = {gate_a,gate_b} = i.

Function
REQ-015 FSM states SHALL be IDLE, APPLY, SAMPLE, DONE.
REQ-016 IDLE: gate_a=gate_b=0, busy=0; start=1 -> latch op_sel, vec=0, hold count=0, err_cnt=0, fail_mask=0, pass=0, go APPLY.
REQ-017 op_sel SHALL be latched at start; changes during a sweep SHALL have no effect.
REQ-018 APPLY: gate_a=vec[1], gate_b=vec[0]; stay exactly HOLD_CYCLES cycles, then go SAMPLE.
REQ-019 SAMPLE: one cycle, gate_a/gate_b unchanged; compare gate_f with expected function of (vec[1],vec[0]); on mismatch increment err_cnt and set fail_mask[vec].
REQ-020 SAMPLE with vec<3 -> vec+1, hold count=0, go APPLY; vec==3 -> go DONE.
REQ-021 DONE: one cycle; done=1, pass=(err_cnt==0), busy=0, gate_a=gate_b=0; then IDLE.
REQ-022 Sweep latency: done SHALL assert exactly 4*(HOLD_CYCLES+1) cycles after the edge that samples start (20 cycles at default).
REQ-023 busy SHALL be 1 in APPLY and SAMPLE, 0 in IDLE and DONE.
REQ-024 start while not in IDLE (including DONE cycle) SHALL be ignored.
REQ-025 abort=1 in APPLY or SAMPLE -> go IDLE next edge; no done pulse; pass=0; err_cnt and fail_mask hold values at abort; gate_a=gate_b=0.
REQ-026 abort in IDLE or DONE SHALL have no effect; abort and start same cycle in IDLE -> start wins.
REQ-027 Mismatch in a SAMPLE cycle coinciding with abort SHALL NOT be recorded.
REQ-028 err_cnt SHALL never wrap (max 4 by construction).

Reset
REQ-029 rst_n low SHALL immediately force IDLE, gate_a=0, gate_b=0, busy=0, done=0, pass=0, err_cnt=0, fail_mask=0, vec=0, hold count=0, regardless of clock.
REQ-030 Reset asserted mid-sweep SHALL discard the sweep; after release the block waits in IDLE for a new start.

Verification
REQ-031 Ideal NOR model on gate_f, op_sel=3, HOLD_CYCLES=4, start pulse -> vectors 00,01,10,11 each held 5 cycles; done 20 cycles after start; pass=1, err_cnt=0, fail_mask=0000.
REQ-032 gate_f tied 0, op_sel=3 -> err_cnt=1, fail_mask=0001, pass=0.
REQ-033 NOR model, op_sel=4 (XOR) -> err_cnt=3, fail_mask=0111, pass=0.
REQ-034 NOR model, abort during APPLY of vector 2 -> IDLE next cycle, no done, pass=0, gate_a=gate_b=0, fail_mask=0000; start pulse during the sweep and in DONE cycle -> ignored, done still at cycle 20.
REQ-035 rst_n pulsed low mid-sweep (between clock edges) -> all outputs 0 immediately; new start after release -> full sweep with correct result.
REQ-036 HOLD_CYCLES=1 and HOLD_CYCLES=0 -> done 8 cycles after start in both cases, results as REQ-031.
